// File: rtl/spi_shift_engine_if.sv
// FIFO-side handshake and SPI pin bundle for spi_shift_engine.
// The master modport is the shift engine's view; the slave modport is the
// view of whatever drives the FIFO flags/data and the MISO pin.
interface spi_shift_engine_if #(
  parameter int WIDTH = 8
);
  logic             tx_empty;
  logic [WIDTH-1:0] tx_data;
  logic             tx_rd;
  logic             rx_full;
  logic             rx_wr;
  logic [WIDTH-1:0] rx_data;
  logic             sck;
  logic             mosi;
  logic             miso;

  modport master (
    input  tx_empty, tx_data, rx_full, miso,
    output tx_rd, rx_wr, rx_data, sck, mosi
  );

  modport slave (
    output tx_empty, tx_data, rx_full, miso,
    input  tx_rd, rx_wr, rx_data, sck, mosi
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: pops one word from the TX FIFO, shifts it out on
// MOSI while shifting MISO in, then pushes the received word to the RX FIFO.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | SCK parked at cpol; waits for en & TX data & RX space
// ST_LOAD  | tx_rd pulse; word and configuration already captured
// ST_SHIFT | divider runs; 2*WIDTH SCK edges, sample/shift by cpha
// ST_STORE | rx_wr pulse with the received word
module spi_shift_engine #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,      // asynchronous, active low
  input  logic             i_en,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [DIV_W-1:0] i_clkdiv,
  spi_shift_engine_if.master bus,
  output logic             o_busy
);

  localparam int EDGE_W = $clog2(2 * WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_tx_sr;
  logic [WIDTH-1:0]   r_rx_sr;
  logic [WIDTH-1:0]   r_rx_data;
  logic [EDGE_W-1:0]  r_edge;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_clkdiv;
  logic               r_cpol;
  logic               r_cpha;
  logic               r_sck;
  logic               r_tx_rd;
  logic               r_rx_wr;
  logic               r_busy;

  logic               w_start;
  logic               w_tick;
  logic               w_odd;
  logic               w_sample;
  logic               w_shift;
  logic               w_last;
  logic [WIDTH-1:0]   w_rx_next;

  // Start and per-edge decode; edge parity selects leading/trailing action.
  assign w_start   = i_en & ~bus.tx_empty & ~bus.rx_full;
  assign w_tick    = (r_div == '0);
  assign w_odd     = r_edge[0];
  assign w_last    = (r_edge == LAST_EDGE);
  assign w_sample  = r_cpha ? w_odd : ~w_odd;
  // cpha=0 shifts on trailing edges except the final one; cpha=1 shifts on
  // leading edges except the first, so bit WIDTH-1 is held from LOAD.
  assign w_shift   = r_cpha ? (~w_odd && (r_edge != '0)) : (w_odd && !w_last);
  assign w_rx_next = {r_rx_sr[WIDTH-2:0], bus.miso};

  // Single registered FSM: all outputs come straight from flops.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_edge    <= '0;
      r_div     <= '0;
      r_clkdiv  <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sck     <= 1'b0;
      r_tx_rd   <= 1'b0;
      r_rx_wr   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_tx_rd <= 1'b0;
      r_rx_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sck <= i_cpol;
          if (w_start) begin
            // Capture on entry to LOAD so MOSI shows the MSB during LOAD and
            // the FIFO pop at the end of LOAD cannot disturb the word.
            r_state  <= ST_LOAD;
            r_tx_rd  <= 1'b1;
            r_busy   <= 1'b1;
            r_tx_sr  <= bus.tx_data;
            r_cpol   <= i_cpol;
            r_cpha   <= i_cpha;
            r_clkdiv <= i_clkdiv;
            r_div    <= i_clkdiv;
            r_edge   <= '0;
            r_rx_sr  <= '0;
          end
        end

        ST_LOAD: begin
          r_state <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (w_tick) begin
            r_div  <= r_clkdiv;
            r_edge <= r_edge + 1'b1;
            if (w_sample) begin
              r_rx_sr <= w_rx_next;
            end
            if (w_shift) begin
              r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
            end
            if (w_last) begin
              // Final edge always lands on the idle level.
              r_sck     <= r_cpol;
              r_state   <= ST_STORE;
              r_rx_wr   <= 1'b1;
              r_rx_data <= w_sample ? w_rx_next : r_rx_sr;
            end else begin
              r_sck <= ~r_sck;
            end
          end else begin
            r_div <= r_div - 1'b1;
          end
        end

        ST_STORE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping.
  assign bus.sck     = r_sck;
  assign bus.mosi    = r_tx_sr[WIDTH-1];
  assign bus.tx_rd   = r_tx_rd;
  assign bus.rx_wr   = r_rx_wr;
  assign bus.rx_data = r_rx_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a small TX FIFO model and
// MOSI->MISO loopback option.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] clkdiv = 8'd0;
  logic       rx_full = 1'b0;
  logic       loop = 1'b1;
  logic       miso_val = 1'b0;
  logic       busy;

  logic [7:0] txq [8];
  int         txq_wr = 0;
  int         txq_rd = 0;

  int         n_rd = 0;
  int         n_wr = 0;
  int         n_both = 0;
  int         n_sck = 0;
  int         n_rise = 0;
  logic [15:0] rise_bits = '0;
  logic       sck_prev = 1'b0;

  int         n_cmp = 0;
  int         n_err = 0;

  spi_shift_engine_if #(.WIDTH(8)) bus ();

  spi_shift_engine #(.WIDTH(8), .DIV_W(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_en     (en),
    .i_cpol   (cpol),
    .i_cpha   (cpha),
    .i_clkdiv (clkdiv),
    .bus      (bus.master),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  assign bus.tx_empty = (txq_wr == txq_rd);
  assign bus.tx_data  = txq[txq_rd[2:0]];
  assign bus.rx_full  = rx_full;
  assign bus.miso     = loop ? bus.mosi : miso_val;

  // Monitor: FIFO pop, pulse counters, SCK edge tracking, MOSI at SCK rise.
  always @(negedge clk) begin
    if (bus.tx_rd) begin
      n_rd   <= n_rd + 1;
      txq_rd <= txq_rd + 1;
    end
    if (bus.rx_wr) n_wr <= n_wr + 1;
    if (bus.tx_rd && bus.rx_wr) n_both <= n_both + 1;
    if (bus.sck !== sck_prev) begin
      n_sck <= n_sck + 1;
      if (bus.sck) begin
        n_rise    <= n_rise + 1;
        rise_bits <= {rise_bits[14:0], bus.mosi};
      end
    end
    sck_prev <= bus.sck;
  end

  task automatic push(input logic [7:0] d);
    txq[txq_wr % 8] = d;
    txq_wr = txq_wr + 1;
  endtask

  // Waits for tx_rd; k = negedges waited, -1 on timeout.
  task automatic wait_rd(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.tx_rd) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_wr(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.rx_wr) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic set_mode(input logic p, input logic h, input logic [7:0] d);
    @(negedge clk);
    cpol = p; cpha = h; clkdiv = d;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    cpol = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({bus.sck, bus.mosi, bus.tx_rd, bus.rx_wr, busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 00000",
                        {bus.sck, bus.mosi, bus.tx_rd, bus.rx_wr, busy});
    end
    n_cmp++; if (bus.rx_data !== 8'h00) begin
      n_err++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.sck !== 1'b0) begin
      n_err++; $display("FAIL reset_sck_before_edge: got %b expected 0", bus.sck);
    end
    @(negedge clk);
    n_cmp++; if (bus.sck !== 1'b1) begin
      n_err++; $display("FAIL reset_sck_cpol: got %b expected 1", bus.sck);
    end
  endtask

  task automatic test_flow_empty;
    int r0, w0, s0;
    logic bad;
    en = 1'b1;
    #1;
    r0 = n_rd; w0 = n_wr; s0 = n_sck;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || bus.tx_rd || bus.rx_wr || (bus.sck !== cpol)) bad = 1'b1;
    end
    #1;
    n_cmp++; if (bad !== 1'b0) begin
      n_err++; $display("FAIL empty_idle_static: got bad=%b expected 0", bad);
    end
    n_cmp++; if ((n_rd - r0) !== 0 || (n_wr - w0) !== 0) begin
      n_err++; $display("FAIL empty_pulses: got rd=%0d wr=%0d expected 0 0",
                        n_rd - r0, n_wr - w0);
    end
    n_cmp++; if ((n_sck - s0) !== 0) begin
      n_err++; $display("FAIL empty_sck_edges: got %0d expected 0", n_sck - s0);
    end
  endtask

  task automatic test_mode0;
    int r0, s0, k;
    set_mode(1'b0, 1'b0, 8'd0);
    loop = 1'b1;
    #1;
    r0 = n_rd; s0 = n_sck;
    push(8'hA5);
    wait_rd(10, k);
    n_cmp++; if (k !== 1) begin
      n_err++; $display("FAIL m0_load_latency: got %0d expected 1", k);
    end
    n_cmp++; if ({busy, bus.mosi} !== 2'b11) begin
      n_err++; $display("FAIL m0_load_busy_mosi: got %b expected 11", {busy, bus.mosi});
    end
    wait_wr(40, k);
    n_cmp++; if (k !== 17) begin
      n_err++; $display("FAIL m0_store_cycle: got %0d expected 17", k);
    end
    n_cmp++; if (bus.rx_data !== 8'hA5) begin
      n_err++; $display("FAIL m0_rx_data: got %h expected a5", bus.rx_data);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ((n_rd - r0) !== 1) begin
      n_err++; $display("FAIL m0_tx_rd_count: got %0d expected 1", n_rd - r0);
    end
    n_cmp++; if ((n_sck - s0) !== 16 || bus.sck !== 1'b0) begin
      n_err++; $display("FAIL m0_sck: got edges=%0d idle=%b expected 16 0",
                        n_sck - s0, bus.sck);
    end
  endtask

  task automatic test_mode3;
    int q0, k, k_fall, k_rise;
    set_mode(1'b1, 1'b1, 8'd3);
    loop = 1'b0;
    miso_val = 1'b1;
    #1;
    q0 = n_rise;
    push(8'h3C);
    wait_rd(10, k);
    n_cmp++; if (k !== 1) begin
      n_err++; $display("FAIL m3_load_latency: got %0d expected 1", k);
    end
    k_fall = -1; k_rise = -1; k = -1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (k_fall < 0 && bus.sck === 1'b0) k_fall = i;
      if (k_fall > 0 && k_rise < 0 && bus.sck === 1'b1) k_rise = i;
      if (bus.rx_wr) begin
        k = i;
        break;
      end
    end
    n_cmp++; if (k_fall !== 5 || k_rise !== 9) begin
      n_err++; $display("FAIL m3_half_period: got fall=%0d rise=%0d expected 5 9",
                        k_fall, k_rise);
    end
    n_cmp++; if (k !== 65) begin
      n_err++; $display("FAIL m3_store_cycle: got %0d expected 65", k);
    end
    n_cmp++; if (bus.rx_data !== 8'hFF) begin
      n_err++; $display("FAIL m3_rx_data: got %h expected ff", bus.rx_data);
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ((n_rise - q0) !== 8 || rise_bits[7:0] !== 8'h3C) begin
      n_err++; $display("FAIL m3_mosi_seq: got rises=%0d bits=%b expected 8 00111100",
                        n_rise - q0, rise_bits[7:0]);
    end
    n_cmp++; if (bus.sck !== 1'b1) begin
      n_err++; $display("FAIL m3_sck_idle: got %b expected 1", bus.sck);
    end
    loop = 1'b1;
  endtask

  task automatic test_back_to_back;
    int r0, w0, k;
    set_mode(1'b0, 1'b0, 8'd0);
    #1;
    r0 = n_rd; w0 = n_wr;
    push(8'h12);
    push(8'h34);
    wait_rd(10, k);
    wait_wr(40, k);
    n_cmp++; if (k !== 17 || bus.rx_data !== 8'h12) begin
      n_err++; $display("FAIL b2b_first: got cyc=%0d data=%h expected 17 12", k, bus.rx_data);
    end
    wait_rd(10, k);
    n_cmp++; if (k !== 2) begin
      n_err++; $display("FAIL b2b_gap: got %0d expected 2", k);
    end
    wait_wr(40, k);
    n_cmp++; if (k !== 17 || bus.rx_data !== 8'h34) begin
      n_err++; $display("FAIL b2b_second: got cyc=%0d data=%h expected 17 34", k, bus.rx_data);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ((n_rd - r0) !== 2 || (n_wr - w0) !== 2) begin
      n_err++; $display("FAIL b2b_counts: got rd=%0d wr=%0d expected 2 2",
                        n_rd - r0, n_wr - w0);
    end
    n_cmp++; if (n_both !== 0) begin
      n_err++; $display("FAIL b2b_overlap: got %0d expected 0", n_both);
    end
  endtask

  task automatic test_rx_full;
    int r0, k;
    @(negedge clk);
    rx_full = 1'b1;
    push(8'h5A);
    #1;
    r0 = n_rd;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if ((n_rd - r0) !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rxfull_hold: got rd=%0d busy=%b expected 0 0", n_rd - r0, busy);
    end
    rx_full = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.tx_rd !== 1'b1) begin
      n_err++; $display("FAIL rxfull_release_load: got %b expected 1", bus.tx_rd);
    end
    wait_wr(40, k);
    n_cmp++; if (k !== 17 || bus.rx_data !== 8'h5A) begin
      n_err++; $display("FAIL rxfull_data: got cyc=%0d data=%h expected 17 5a", k, bus.rx_data);
    end
  endtask

  task automatic test_en_drop;
    int r0, w0, k;
    repeat (2) @(negedge clk);
    #1;
    r0 = n_rd; w0 = n_wr;
    push(8'h81);
    push(8'h42);
    push(8'h24);
    wait_rd(10, k);
    repeat (6) @(negedge clk);
    en = 1'b0;
    wait_wr(40, k);
    n_cmp++; if (k !== 11 || bus.rx_data !== 8'h81) begin
      n_err++; $display("FAIL endrop_complete: got cyc=%0d data=%h expected 11 81", k, bus.rx_data);
    end
    repeat (30) @(negedge clk);
    #1;
    n_cmp++; if ((n_rd - r0) !== 1 || (n_wr - w0) !== 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL endrop_no_more: got rd=%0d wr=%0d busy=%b expected 1 1 0",
                        n_rd - r0, n_wr - w0, busy);
    end
  endtask

  task automatic test_reset_abort;
    int w0, k;
    #1;
    w0 = n_wr;
    en = 1'b1;
    wait_rd(10, k);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.sck, bus.mosi, bus.tx_rd, bus.rx_wr, busy, bus.rx_data} !== 13'h0) begin
      n_err++; $display("FAIL abort_async_outputs: got %h expected 0000",
                        {bus.sck, bus.mosi, bus.tx_rd, bus.rx_wr, busy, bus.rx_data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if ((n_wr - w0) !== 0) begin
      n_err++; $display("FAIL abort_no_rx_wr: got %0d expected 0", n_wr - w0);
    end
    wait_wr(60, k);
    n_cmp++; if (k < 0 || bus.rx_data !== 8'h24) begin
      n_err++; $display("FAIL abort_next_word: got cyc=%0d data=%h expected 24", k, bus.rx_data);
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ((n_wr - w0) !== 1) begin
      n_err++; $display("FAIL abort_wr_count: got %0d expected 1", n_wr - w0);
    end
  endtask

  initial begin
    test_reset();
    test_flow_empty();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_rx_full();
    test_en_drop();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
